// File: rtl/ram_2r_2w_fifo_ctl.sv
// Dual-push / dual-pop circular-queue controller for a 2R/2W synchronous DFF RAM.
// Pushes are judged against the pre-pop count, and pops against the pre-push count.
module ram_2r_2w_fifo_ctl #(
  parameter int unsigned addr_width = 3,
  parameter bit          err_mode   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0_n,
  input  logic                  push1_n,
  input  logic                  pop0_n,
  input  logic                  pop1_n,
  output logic                  en_w1_n,
  output logic [addr_width-1:0] addr_w1,
  output logic                  en_w2_n,
  output logic [addr_width-1:0] addr_w2,
  output logic                  en_r1_n,
  output logic [addr_width-1:0] addr_r1,
  output logic                  en_r2_n,
  output logic [addr_width-1:0] addr_r2,
  output logic                  push0_ack,
  output logic                  push1_ack,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [addr_width:0]   word_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [addr_width:0]   depth_c = (addr_width + 1)'(1 << addr_width);
  localparam logic [addr_width:0]   cnt_one = (addr_width + 1)'(1);
  localparam logic [addr_width:0]   cnt_two = (addr_width + 1)'(2);
  localparam logic [addr_width-1:0] ptr_one = addr_width'(1);

  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   count, free, n_push, n_pop;
  logic                  push0_req, push1_req, pop0_req, pop1_req;
  logic                  pop0_acc, pop1_acc, ovf_now, unf_now;

  assign push0_req = ~push0_n;
  assign push1_req = ~push1_n;
  assign pop0_req  = ~pop0_n;
  assign pop1_req  = ~pop1_n;
  assign free      = depth_c - count;

  // Acks are gated by rst_n so no RAM write can fire while reset is held.
  always_comb begin
    push0_ack = 1'b0;
    push1_ack = 1'b0;
    if (rst_n) begin
      if (push0_req && push1_req) begin
        push0_ack = (free >= cnt_one);
        push1_ack = (free >= cnt_two);
      end else if (push0_req) begin
        push0_ack = (free >= cnt_one);
      end else if (push1_req) begin
        push1_ack = (free >= cnt_one);
      end
    end
  end

  always_comb begin
    pop0_acc = rst_n & pop0_req & (count >= cnt_one);
    pop1_acc = rst_n & pop0_req & pop1_req & (count >= cnt_two);
    ovf_now  = (push0_req & ~push0_ack) | (push1_req & ~push1_ack);
    unf_now  = (pop0_req & ~pop0_acc) | (pop1_req & ~pop1_acc);
    n_push   = (addr_width + 1)'(push0_ack) + (addr_width + 1)'(push1_ack);
    n_pop    = (addr_width + 1)'(pop0_acc) + (addr_width + 1)'(pop1_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + n_push[addr_width-1:0];
      rd_ptr <= rd_ptr + n_pop[addr_width-1:0];
      count  <= count + n_push - n_pop;
      if (err_mode) begin
        overflow  <= ovf_now;
        underflow <= unf_now;
      end else begin
        overflow  <= overflow | ovf_now;
        underflow <= underflow | unf_now;
      end
    end
  end

  // A lone slot-1 push lands at wr_ptr; it only takes wr_ptr+1 when slot 0 also writes.
  always_comb begin
    en_w1_n      = ~push0_ack;
    en_w2_n      = ~push1_ack;
    addr_w1      = wr_ptr;
    addr_w2      = (push0_ack && push1_ack) ? (wr_ptr + ptr_one) : wr_ptr;
    addr_r1      = rd_ptr;
    addr_r2      = rst_n ? (rd_ptr + ptr_one) : '0;
    en_r1_n      = (count == '0);
    en_r2_n      = ~(count >= cnt_two);
    empty        = (count == '0);
    almost_empty = (count <= cnt_one);
    full         = (count == depth_c);
    almost_full  = (count >= depth_c - cnt_one);
    word_count   = count;
  end

endmodule

// File: tb/tb_ram_2r_2w_fifo_ctl.sv
// Directed bench for ram_2r_2w_fifo_ctl with a behavioural 2R/2W RAM attached.
module tb_ram_2r_2w_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst_n, push0_n, push1_n, pop0_n, pop1_n;
  logic       en_w1_n, en_w2_n, en_r1_n, en_r2_n;
  logic [2:0] addr_w1, addr_w2, addr_r1, addr_r2;
  logic       push0_ack, push1_ack, empty, almost_empty, full, almost_full;
  logic [3:0] word_count;
  logic       overflow, underflow;
  logic [7:0] data_w1, data_w2, data_r1, data_r2;
  logic [7:0] mem [8];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  ram_2r_2w_fifo_ctl #(.addr_width(3), .err_mode(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .push0_n(push0_n), .push1_n(push1_n), .pop0_n(pop0_n), .pop1_n(pop1_n),
    .en_w1_n(en_w1_n), .addr_w1(addr_w1), .en_w2_n(en_w2_n), .addr_w2(addr_w2),
    .en_r1_n(en_r1_n), .addr_r1(addr_r1), .en_r2_n(en_r2_n), .addr_r2(addr_r2),
    .push0_ack(push0_ack), .push1_ack(push1_ack),
    .empty(empty), .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
    .word_count(word_count), .overflow(overflow), .underflow(underflow)
  );

  always @(posedge clk) begin
    if (!en_w1_n) mem[addr_w1] <= data_w1;
    if (!en_w2_n) mem[addr_w2] <= data_w2;
  end
  assign data_r1 = mem[addr_r1];
  assign data_r2 = mem[addr_r2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p0, input logic p1, input logic q0, input logic q1);
    push0_n = ~p0; push1_n = ~p1; pop0_n = ~q0; pop1_n = ~q1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_empty"}, empty, 1);
    chk({pfx, "_aempty"}, almost_empty, 1);
    chk({pfx, "_full"}, full, 0);
    chk({pfx, "_afull"}, almost_full, 0);
    chk({pfx, "_wc"}, word_count, 0);
    chk({pfx, "_ovf"}, overflow, 0);
    chk({pfx, "_unf"}, underflow, 0);
    chk({pfx, "_enw1"}, en_w1_n, 1);
    chk({pfx, "_enw2"}, en_w2_n, 1);
    chk({pfx, "_enr1"}, en_r1_n, 1);
    chk({pfx, "_enr2"}, en_r2_n, 1);
    chk({pfx, "_aw1"}, addr_w1, 0);
    chk({pfx, "_aw2"}, addr_w2, 0);
    chk({pfx, "_ar1"}, addr_r1, 0);
    chk({pfx, "_ar2"}, addr_r2, 0);
    chk({pfx, "_ack0"}, push0_ack, 0);
    chk({pfx, "_ack1"}, push1_ack, 0);
  endtask

  initial begin
    rst_n = 1'b0; drive(0, 0, 0, 0); data_w1 = '0; data_w2 = '0;
    #2;
    drive(1, 1, 1, 1);
    #1;
    chk_reset_outputs("rst");
    drive(0, 0, 0, 0);
    #5 rst_n = 1'b1;
    tick();

    // fill to full with dual pushes
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0); data_w1 = 8'(8'h10 + 2 * i); data_w2 = 8'(8'h11 + 2 * i);
      #1;
      chk("fill_aw1", addr_w1, 2 * i);
      chk("fill_aw2", addr_w2, 2 * i + 1);
      chk("fill_acks", {push0_ack, push1_ack, en_w1_n, en_w2_n}, 4'b1100);
      tick();
      chk("fill_wc", word_count, 2 * (i + 1));
    end
    drive(0, 0, 0, 0);
    chk("fill_full", {full, almost_full, empty}, 3'b110);

    // drain with dual pops
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1);
      #1;
      chk("drain_r1", data_r1, 8'h10 + 2 * i);
      chk("drain_r2", data_r2, 8'h11 + 2 * i);
      chk("drain_en", {en_r1_n, en_r2_n}, 2'b00);
      tick();
      chk("drain_wc", word_count, 8 - 2 * (i + 1));
    end
    drive(0, 0, 0, 0);
    chk("drain_flags", {empty, almost_empty, overflow, underflow}, 4'b1100);

    // seven entries, then a dual push with one free slot
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0); data_w1 = 8'(8'h20 + 2 * i); data_w2 = 8'(8'h21 + 2 * i);
      tick();
    end
    drive(1, 0, 0, 0); data_w1 = 8'h26;
    tick();
    chk("seven_wc", word_count, 7);
    chk("seven_afull", {almost_full, full}, 2'b10);
    drive(1, 1, 0, 0); data_w1 = 8'h27; data_w2 = 8'h99;
    #1;
    chk("ovf_acks", {push0_ack, push1_ack, en_w1_n, en_w2_n}, 4'b1001);
    chk("ovf_aw1", addr_w1, 7);
    tick();
    chk("ovf_wc", word_count, 8);
    chk("ovf_flag", {overflow, full}, 2'b11);
    drive(0, 0, 0, 0);
    tick();
    chk("ovf_sticky", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1);
      #1;
      chk("drain2_r1", data_r1, 8'h20 + 2 * i);
      chk("drain2_r2", data_r2, 8'h21 + 2 * i);
      tick();
    end
    chk("drain2_wc", word_count, 0);

    // push0 + pop0 on empty
    drive(1, 0, 1, 0); data_w1 = 8'h30;
    #1;
    chk("pe_ack", {push0_ack, en_r1_n}, 2'b11);
    tick();
    chk("pe_wc", word_count, 1);
    chk("pe_flags", {underflow, almost_empty, empty}, 3'b110);
    drive(0, 0, 1, 0);
    #1;
    chk("pop1w_r1", data_r1, 8'h30);
    chk("pop1w_enr2", en_r2_n, 1);
    tick();
    chk("pop1w_wc", word_count, 0);

    // walk both pointers to 7
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0); data_w1 = 8'(8'h31 + 2 * i); data_w2 = 8'(8'h32 + 2 * i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1);
      #1;
      chk("walk_r1", data_r1, 8'h31 + 2 * i);
      chk("walk_r2", data_r2, 8'h32 + 2 * i);
      tick();
    end

    // pointer wrap
    drive(1, 1, 0, 0); data_w1 = 8'h40; data_w2 = 8'h41;
    #1;
    chk("wrap_aw1", addr_w1, 7);
    chk("wrap_aw2", addr_w2, 0);
    tick();
    chk("wrap_wc", word_count, 2);
    drive(0, 0, 1, 1);
    #1;
    chk("wrap_ar", {addr_r1, addr_r2}, {3'd7, 3'd0});
    chk("wrap_r1", data_r1, 8'h40);
    chk("wrap_r2", data_r2, 8'h41);
    tick();
    chk("wrap_wc0", word_count, 0);

    // clear sticky flags, then lone pop1 with count 3
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("clr_flags", {overflow, underflow}, 2'b00);
    rst_n = 1'b1;
    tick();
    drive(1, 1, 0, 0); data_w1 = 8'h50; data_w2 = 8'h51;
    tick();
    drive(1, 0, 0, 0); data_w1 = 8'h52;
    tick();
    chk("p1_pre_wc", word_count, 3);
    drive(0, 0, 0, 1);
    tick();
    chk("p1_wc", word_count, 3);
    chk("p1_unf", underflow, 1);
    chk("p1_head", {addr_r1, data_r1}, {3'd0, 8'h50});

    // asynchronous reset mid-stream
    drive(1, 1, 1, 1); data_w1 = 8'h60; data_w2 = 8'h61;
    #1;
    chk("mid_ack", push0_ack, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    drive(0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_2r_2w_fifo_ctl.md
Name: ram_2r_2w_fifo_ctl

Overview:
- Dual-push / dual-pop FIFO controller that sequences a 2-read/2-write synchronous DFF RAM (depth 2^addr_width) as a circular queue.
- Accepts up to two pushes and two pops per cycle.
- Generates the RAM write/read enables and addresses, and tracks occupancy and errors.
- Sits between producer/consumer logic and the RAM. Write data goes from the producer straight to the RAM data_w1/data_w2 ports; read data comes straight from the RAM data_r1/data_r2 ports to the consumer.

Parameters:
- addr_width, 3, RAM address width; depth = 2^addr_width; legal range 2..8.
- err_mode, 0, 0 = error flags sticky until reset; 1 = error flags reflect the current cycle only.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- push0_n  input  1  push request slot 0 (active low); producer drives its data on RAM data_w1.
- push1_n  input  1  push request slot 1 (active low); producer drives its data on RAM data_w2.
- pop0_n  input  1  pop request for the head word (active low).
- pop1_n  input  1  pop request for the word after the head (active low).
- en_w1_n  output  1  RAM write port 1 enable.
- addr_w1  output  addr_width  RAM write port 1 address.
- en_w2_n  output  1  RAM write port 2 enable.
- addr_w2  output  addr_width  RAM write port 2 address.
- en_r1_n  output  1  RAM read port 1 enable.
- addr_r1  output  addr_width  RAM read port 1 address (head).
- en_r2_n  output  1  RAM read port 2 enable.
- addr_r2  output  addr_width  RAM read port 2 address (head+1).
- push0_ack  output  1  push slot 0 accepted this cycle (combinational).
- push1_ack  output  1  push slot 1 accepted this cycle (combinational).
- empty  output  1  count == 0.
- almost_empty  output  1  count <= 1.
- full  output  1  count == depth.
- almost_full  output  1  count >= depth-1.
- word_count  output  addr_width+1  current occupancy.
- overflow  output  1  a push was rejected.
- underflow  output  1  a pop was rejected.

Behaviour:
- State:
  - wr_ptr, rd_ptr: addr_width bits each, wrap modulo depth.
  - count: addr_width+1 bits, range 0..depth.
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = count = 0; overflow = underflow = 0.
  - Outputs during reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, word_count = 0.
  - All RAM enables high (inactive); all RAM addresses 0.
  - Reset mid-operation discards queue contents; RAM contents are not cleared.
- Space and push acceptance (free = depth - count, using the pre-pop count; no same-cycle pass-through of pops into free space):
  - Both slots request, free >= 2: both accepted; slot0 -> wr_ptr, slot1 -> wr_ptr+1; wr_ptr += 2.
  - Both slots request, free == 1: slot0 accepted at wr_ptr; slot1 rejected -> overflow.
  - Both slots request, free == 0: both rejected -> overflow.
  - Only one slot requests, free >= 1: that slot is written at wr_ptr (addr_w1 for slot0, addr_w2 for slot1); wr_ptr += 1.
  - Only one slot requests, free == 0: rejected -> overflow.
- RAM write side:
  - en_w1_n = ~push0_ack; en_w2_n = ~push1_ack.
  - The two write addresses are never equal when both enables are low.
  - Writes are combinational from the requests and state; the RAM captures them at the same clock edge.
- RAM read side:
  - addr_r1 = rd_ptr and addr_r2 = rd_ptr+1, registered-state driven.
  - en_r1_n = empty; en_r2_n = ~(count >= 2).
  - Read data is valid in the same cycle as the pop decision; zero-latency head view.
- Pop rules (pops evaluated against the pre-push count; a word written this cycle cannot be popped this cycle):
  - pop0 alone: accepted if count >= 1.
  - pop0 + pop1: both accepted if count >= 2; only pop0 accepted if count == 1.
  - pop1 without pop0: always rejected -> underflow.
  - Each rejection sets underflow. rd_ptr += number of accepted pops.
- Counter update: count_next = count + pushes_accepted - pops_accepted. Simultaneous push and pop at full or empty is resolved by the pre-state rules above.
- Error flags:
  - err_mode 0: overflow/underflow set on the edge following the error and hold until reset.
  - err_mode 1: overflow/underflow are registered one-cycle pulses.
- Pointer wrap: wr_ptr+1 and rd_ptr+1 wrap modulo depth (e.g. ptr 7 -> 0 for addr_width 3).

Test Plan (addr_width = 3, err_mode = 0):
1. Reset, then push0 + push1 for 4 cycles with data 0x10..0x17 -> addr_w1/addr_w2 = 0/1, 2/3, 4/5, 6/7; push acks high each cycle; word_count 2, 4, 6, 8; full = 1 after the last edge.
2. From full, pop0 + pop1 for 4 cycles -> data_r1/data_r2 = 0x10/0x11 .. 0x16/0x17; word_count 6, 4, 2, 0; empty = 1; no errors.
3. With 7 entries, push0 + push1 -> push0_ack = 1, push1_ack = 0, word_count 8, overflow = 1 and remains sticky.
4. From empty, push0 + pop0 together -> push accepted, pop rejected, underflow = 1, word_count 1.
5. Pointer wrap: with wr_ptr = 7 and rd_ptr = 7, push0 + push1 -> addr_w1 = 7, addr_w2 = 0; subsequent dual pop reads addr_r1 = 7, addr_r2 = 0, returning data in order.
6. pop1 alone with count 3 -> rejected, underflow = 1, count unchanged. Then assert rst_n low mid-stream -> all outputs at reset values immediately (asynchronously).
